pipe_ctrl: RTL and testbench

//  Pipeline sequencer downstream of the ID hazard detector: consumes data_hazard_ID plus EX/MEM busy and
//  EX redirect, owns the ID/EX/MEM/WB valid bits, and produces per-stage advance enables and bubble insertion.
//  Its registered valids feed back to the hazard detector and gate every pipeline register in the core.

---
 rtl/pipe_pkg.sv | 18 +
 rtl/sat_counter.sv | 24 ++
 rtl/pipe_ctrl.sv | 115 +++++++++++
 tb/tb_pipe_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and stage indices for the pipeline sequencer.
package pipe_pkg;

  localparam int STAGE_ID  = 0;
  localparam int STAGE_EX  = 1;
  localparam int STAGE_MEM = 2;
  localparam int STAGE_WB  = 3;
  localparam int N_STAGES  = 4;

  // Per-stage control: the current valid bit, whether the stage loads this
  // cycle, and whether what it loads is forced to a bubble.
  typedef struct packed {
    logic valid;
    logic en;
    logic bubble;
  } stage_ctl_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  // Count up until all ones, then hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: owns ID/EX/MEM/WB valid bits, derives per-stage
// advance enables and bubble insertion from busy/redirect/hazard inputs,
// and keeps saturating performance counters.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_valid,
  output logic             if_ready,
  input  logic             data_hazard_ID,
  input  logic             ex_busy,
  input  logic             mem_busy,
  input  logic             ex_redirect,
  output logic             id_valid,
  output logic             ex_valid,
  output logic             mem_valid,
  output logic             wb_valid,
  output logic             id_en,
  output logic             ex_en,
  output logic             mem_en,
  output logic             fetch_redirect,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] hazard_cnt,
  output logic [CNT_W-1:0] redirect_cnt
);

  logic [N_STAGES-1:0] r_valid;
  logic [N_STAGES-1:0] w_prev;
  stage_ctl_t          w_ctl [N_STAGES];

  logic w_mem_stall;
  logic w_ex_stall;
  logic w_redirect_fire;
  logic w_id_stall;
  logic w_hazard_stall;

  // Stall chain: a stalled stage stalls everything above it. A redirect is
  // held while EX is stalled and overrides an ID hazard once it fires.
  assign w_mem_stall     = r_valid[STAGE_MEM] & mem_busy;
  assign w_ex_stall      = w_mem_stall | (r_valid[STAGE_EX] & ex_busy);
  assign w_redirect_fire = r_valid[STAGE_EX] & ex_redirect & ~w_ex_stall;
  assign w_hazard_stall  = ~w_ex_stall & ~w_redirect_fire & data_hazard_ID & r_valid[STAGE_ID];
  assign w_id_stall      = w_ex_stall | w_hazard_stall;

  // What each stage would load when it advances: the valid from the stage above.
  assign w_prev = {r_valid[STAGE_MEM], r_valid[STAGE_EX], r_valid[STAGE_ID], if_valid};

  // Per-stage enable and bubble: the stage just below the lowest stalled
  // stage takes a bubble; a fired redirect flushes the wrong-path ID/IF slots.
  always_comb begin
    // NOTE: every field gets a default first so no path leaves a latch behind.
    for (int s = 0; s < N_STAGES; s++) begin
      w_ctl[s].valid  = r_valid[s];
      w_ctl[s].en     = 1'b1;
      w_ctl[s].bubble = 1'b0;
    end
    w_ctl[STAGE_ID].en      = ~w_id_stall;
    w_ctl[STAGE_ID].bubble  = w_redirect_fire;
    w_ctl[STAGE_EX].en      = ~w_ex_stall;
    w_ctl[STAGE_EX].bubble  = w_redirect_fire | w_id_stall;
    w_ctl[STAGE_MEM].en     = ~w_mem_stall;
    w_ctl[STAGE_MEM].bubble = w_ex_stall;
    w_ctl[STAGE_WB].en      = 1'b1;
    w_ctl[STAGE_WB].bubble  = w_mem_stall;
  end

  // Stage valid registers: load (or bubble) when enabled, otherwise hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= '0;
    end else begin
      for (int s = 0; s < N_STAGES; s++) begin
        // NOTE: non-blocking so every stage samples the pre-edge valid of the stage above.
        if (w_ctl[s].en) begin
          r_valid[s] <= w_ctl[s].bubble ? 1'b0 : w_prev[s];
        end
      end
    end
  end

  assign id_valid       = w_ctl[STAGE_ID].valid;
  assign ex_valid       = w_ctl[STAGE_EX].valid;
  assign mem_valid      = w_ctl[STAGE_MEM].valid;
  assign wb_valid       = w_ctl[STAGE_WB].valid;
  assign if_ready       = w_ctl[STAGE_ID].en;
  assign id_en          = w_ctl[STAGE_ID].en;
  assign ex_en          = w_ctl[STAGE_EX].en;
  assign mem_en         = w_ctl[STAGE_MEM].en;
  assign fetch_redirect = w_redirect_fire;

  sat_counter #(.W(CNT_W)) u_retired_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (r_valid[STAGE_WB]),
    .count (retired_cnt)
  );

  sat_counter #(.W(CNT_W)) u_hazard_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_hazard_stall),
    .count (hazard_cnt)
  );

  sat_counter #(.W(CNT_W)) u_redirect_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_redirect_fire),
    .count (redirect_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with 4-bit counters so saturation is reachable.
module tb_pipe_ctrl;

  localparam int CNT_W = 4;

  logic             clk;
  logic             reset;
  logic             if_valid;
  logic             if_ready;
  logic             data_hazard_ID;
  logic             ex_busy;
  logic             mem_busy;
  logic             ex_redirect;
  logic             id_valid;
  logic             ex_valid;
  logic             mem_valid;
  logic             wb_valid;
  logic             id_en;
  logic             ex_en;
  logic             mem_en;
  logic             fetch_redirect;
  logic [CNT_W-1:0] retired_cnt;
  logic [CNT_W-1:0] hazard_cnt;
  logic [CNT_W-1:0] redirect_cnt;

  int total = 0;
  int bad   = 0;

  logic [3:0] vld;
  logic [4:0] ens;
  assign vld = {id_valid, ex_valid, mem_valid, wb_valid};
  assign ens = {if_ready, id_en, ex_en, mem_en, fetch_redirect};

  pipe_ctrl #(.CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .data_hazard_ID (data_hazard_ID),
    .ex_busy        (ex_busy),
    .mem_busy       (mem_busy),
    .ex_redirect    (ex_redirect),
    .id_valid       (id_valid),
    .ex_valid       (ex_valid),
    .mem_valid      (mem_valid),
    .wb_valid       (wb_valid),
    .id_en          (id_en),
    .ex_en          (ex_en),
    .mem_en         (mem_en),
    .fetch_redirect (fetch_redirect),
    .retired_cnt    (retired_cnt),
    .hazard_cnt     (hazard_cnt),
    .redirect_cnt   (redirect_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic ifv, input logic hz, input logic exb,
                        input logic memb, input logic redir);
    if_valid       = ifv;
    data_hazard_ID = hz;
    ex_busy        = exb;
    mem_busy       = memb;
    ex_redirect    = redir;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    set_in(0, 0, 0, 0, 0);
    tick();
    reset = 1'b1;
    #1;
  endtask

  initial begin
    reset = 1'b0;
    set_in(0, 0, 0, 0, 0);

    // Reset state
    check("rst_valids", vld, 4'b0000);
    check("rst_ens", ens, 5'b11110);
    check("rst_retired", retired_cnt, 0);
    check("rst_hazard", hazard_cnt, 0);
    check("rst_redirect", redirect_cnt, 0);
    tick();
    reset = 1'b1;

    // Four back-to-back instructions, no stalls
    set_in(1, 0, 0, 0, 0);
    tick(); check("flow_t1", vld, 4'b1000);
    tick(); check("flow_t2", vld, 4'b1100);
    tick(); check("flow_t3", vld, 4'b1110);
    tick(); check("flow_t4", vld, 4'b1111);
    check("flow_ret_t4", retired_cnt, 0);
    set_in(0, 0, 0, 0, 0);
    tick(); check("flow_t5", vld, 4'b0111);
    check("flow_ret_t5", retired_cnt, 1);
    tick(); check("flow_t6", vld, 4'b0011);
    tick(); check("flow_t7", vld, 4'b0001);
    tick(); check("flow_t8", vld, 4'b0000);
    check("flow_ret_t8", retired_cnt, 4);

    // RAW hazard held two cycles
    do_reset();
    set_in(1, 0, 0, 0, 0);
    tick(); check("hz_fill", vld, 4'b1000);
    set_in(1, 1, 0, 0, 0);
    check("hz_ens1", ens, 5'b00110);
    tick(); check("hz_v1", vld, 4'b1000);
    check("hz_cnt1", hazard_cnt, 1);
    check("hz_ens2", ens, 5'b00110);
    tick(); check("hz_v2", vld, 4'b1000);
    check("hz_cnt2", hazard_cnt, 2);
    set_in(1, 0, 0, 0, 0);
    check("hz_release", ens, 5'b11110);
    tick(); check("hz_v3", vld, 4'b1100);
    check("hz_cnt3", hazard_cnt, 2);

    // Memory stall three cycles with a full pipe; hazard during it is not counted
    do_reset();
    set_in(1, 0, 0, 0, 0);
    tick(); tick(); tick(); tick();
    check("ms_full", vld, 4'b1111);
    set_in(1, 1, 0, 1, 0);
    check("ms_ens", ens, 5'b00000);
    tick(); check("ms_v1", vld, 4'b1110);
    check("ms_ret1", retired_cnt, 1);
    tick(); check("ms_v2", vld, 4'b1110);
    tick(); check("ms_v3", vld, 4'b1110);
    check("ms_ret3", retired_cnt, 1);
    check("ms_hz", hazard_cnt, 0);
    check("ms_rd", redirect_cnt, 0);
    set_in(1, 0, 0, 0, 0);
    tick(); check("ms_v4", vld, 4'b1111);
    tick(); check("ms_ret5", retired_cnt, 2);

    // Asynchronous reset mid-stream
    #2;
    reset = 1'b0;
    #1;
    check("arst_valids", vld, 4'b0000);
    check("arst_retired", retired_cnt, 0);
    tick();
    check("arst_hold", vld, 4'b0000);
    check("arst_hold_ret", retired_cnt, 0);
    reset = 1'b1;

    // Redirect held behind a two-cycle EX busy
    do_reset();
    set_in(1, 0, 0, 0, 0);
    tick(); tick();
    check("rd_fill", vld, 4'b1100);
    set_in(1, 0, 1, 0, 1);
    check("rd_busy_ens1", ens, 5'b00010);
    tick(); check("rd_v1", vld, 4'b1100);
    check("rd_busy_ens2", ens, 5'b00010);
    tick(); check("rd_v2", vld, 4'b1100);
    set_in(1, 0, 0, 0, 1);
    check("rd_fire_ens", ens, 5'b11111);
    check("rd_cnt0", redirect_cnt, 0);
    tick(); check("rd_v3", vld, 4'b0010);
    check("rd_cnt1", redirect_cnt, 1);
    set_in(0, 0, 0, 0, 0);

    // Hazard and redirect in the same cycle: redirect wins, no hazard count
    do_reset();
    set_in(1, 0, 0, 0, 0);
    tick(); tick();
    set_in(1, 1, 0, 0, 1);
    check("hzrd_ens", ens, 5'b11111);
    tick(); check("hzrd_v", vld, 4'b0010);
    check("hzrd_hz", hazard_cnt, 0);
    check("hzrd_rd", redirect_cnt, 1);

    // Hazard while EX is busy counts as an EX stall
    do_reset();
    set_in(1, 0, 0, 0, 0);
    tick(); tick();
    set_in(1, 1, 1, 0, 0);
    tick(); check("hzex_v", vld, 4'b1100);
    check("hzex_hz", hazard_cnt, 0);

    // Twenty retirements saturate a 4-bit counter at 15
    do_reset();
    set_in(1, 0, 0, 0, 0);
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 18) check("sat_ret18", retired_cnt, 14);
      if (i == 19) check("sat_ret19", retired_cnt, 15);
    end
    set_in(0, 0, 0, 0, 0);
    for (int i = 21; i <= 24; i++) tick();
    check("sat_drained", vld, 4'b0000);
    check("sat_ret_final", retired_cnt, 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
